// File: rtl/serial_word_receiver.sv
// Serial-to-parallel receiver for the load/shift serial link: assembles WIDTH-bit LSB-first words.
// Optional even-parity check on the end-of-frame slot is enabled by defining SERIAL_RX_PARITY_EN.
module serial_word_receiver #(
  parameter int WIDTH = 4,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_en,
  input  logic             rx_in,
  input  logic             data_ack,
  output logic [WIDTH-1:0] data_out,
  output logic             data_valid,
  output logic [CW-1:0]    counter,
  output logic             busy,
  output logic             overrun,
  output logic             abort_err,
  output logic             parity_err
);

  typedef enum logic [1:0] {IDLE, SHIFT, COMPLETE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] shreg, shreg_next;
  logic [CW-1:0]    counter_next;
  logic             deliver, drop, abort_now;

  // Handshake: a word is offered while data_valid=1; it is consumed on an edge where data_ack=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state   = state;
    shreg_next   = shreg;
    counter_next = counter;
    deliver      = 1'b0;
    drop         = 1'b0;
    abort_now    = 1'b0;
    case (state)
      IDLE: begin
        if (rx_en) begin
          shreg_next    = '0;
          shreg_next[0] = rx_in;
          counter_next  = CW'(1);
          next_state    = SHIFT;
        end else begin
          counter_next = '0;
        end
      end
      SHIFT: begin
        if (rx_en) begin
          for (int i = 0; i < WIDTH; i++) begin
            if (counter == CW'(i)) shreg_next[i] = rx_in;
          end
          counter_next = counter + 1'b1;
          if (counter == CW'(WIDTH - 1)) next_state = COMPLETE;
        end else begin
          // Link dropped before the word was complete: discard it.
          abort_now    = 1'b1;
          shreg_next   = '0;
          counter_next = '0;
          next_state   = IDLE;
        end
      end
      COMPLETE: begin
        if (!data_valid || data_ack) deliver = 1'b1;
        else                         drop    = 1'b1;
        counter_next = '0;
        next_state   = rx_en ? SHIFT : IDLE;
      end
      default: begin
        counter_next = '0;
        next_state   = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      counter    <= '0;
      busy       <= 1'b0;
      data_out   <= '0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
      abort_err  <= 1'b0;
    end else begin
      shreg   <= shreg_next;
      counter <= counter_next;
      busy    <= (next_state != IDLE);
      if (deliver) begin
        data_out   <= shreg;
        data_valid <= 1'b1;
      end else if (data_ack && data_valid) begin
        data_valid <= 1'b0;
      end
      if (drop)      overrun   <= 1'b1;
      if (abort_now) abort_err <= 1'b1;
    end
  end

`ifdef SERIAL_RX_PARITY_EN
  logic parity_q;

  // rx_in in the COMPLETE slot is the even-parity bit; the flag travels with the delivered word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                        parity_q <= 1'b0;
    else if (deliver)                 parity_q <= ((^shreg) != rx_in);
    else if (data_ack && data_valid)  parity_q <= 1'b0;
  end

  assign parity_err = parity_q;
`else
  assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver (WIDTH=4): frames, handshake, overrun, abort, reset, parity.
module tb_serial_word_receiver;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          clk = 1'b0;
  logic          reset;
  logic          rx_en, rx_in, data_ack;
  logic [W-1:0]  data_out;
  logic          data_valid;
  logic [CW-1:0] counter;
  logic          busy, overrun, abort_err, parity_err;

  int total = 0;
  int bad   = 0;

  serial_word_receiver #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx_en      (rx_en),
    .rx_in      (rx_in),
    .data_ack   (data_ack),
    .data_out   (data_out),
    .data_valid (data_valid),
    .counter    (counter),
    .busy       (busy),
    .overrun    (overrun),
    .abort_err  (abort_err),
    .parity_err (parity_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // one clock: apply inputs, take the edge, settle 1 time unit past it
  task automatic cyc(input logic en, input logic din, input logic ack);
    rx_en    = en;
    rx_in    = din;
    data_ack = ack;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic send_bits(input logic [W-1:0] w);
    for (int i = 0; i < W; i++) cyc(1'b1, w[i], 1'b0);
  endtask

  initial begin
    reset = 1'b1; rx_en = 1'b0; rx_in = 1'b0; data_ack = 1'b0;
    cyc(1'b0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("rst_data_out", 32'(data_out), 32'h0);
    check("rst_valid",    32'(data_valid), 32'h0);
    check("rst_counter",  32'(counter), 32'h0);
    check("rst_busy",     32'(busy), 32'h0);
    check("rst_overrun",  32'(overrun), 32'h0);
    check("rst_abort",    32'(abort_err), 32'h0);
    check("rst_parity",   32'(parity_err), 32'h0);
    reset = 1'b0;

    // frame 4'hD with rx_en held for 5 cycles: counter 1,2,3,4 then 0
    cyc(1'b1, 1'b1, 1'b0); check("d_cnt1", 32'(counter), 32'd1); check("d_busy", 32'(busy), 32'h1);
    cyc(1'b1, 1'b0, 1'b0); check("d_cnt2", 32'(counter), 32'd2);
    cyc(1'b1, 1'b1, 1'b0); check("d_cnt3", 32'(counter), 32'd3);
    cyc(1'b1, 1'b1, 1'b0); check("d_cnt4", 32'(counter), 32'd4);
    check("d_not_yet_valid", 32'(data_valid), 32'h0);
    cyc(1'b1, 1'b0, 1'b0); check("d_cnt0", 32'(counter), 32'd0);
    check("d_data", 32'(data_out), 32'hD);
    check("d_valid", 32'(data_valid), 32'h1);

    // back-to-back 4'h3 then 4'hA with ack one cycle after the first valid
    do_reset();
    send_bits(4'h3);
    cyc(1'b1, 1'b0, 1'b0);
    check("b2b_first", 32'(data_out), 32'h3);
    check("b2b_first_v", 32'(data_valid), 32'h1);
    cyc(1'b1, 1'b0, 1'b1);
    check("b2b_ack_clr", 32'(data_valid), 32'h0);
    check("b2b_cnt1", 32'(counter), 32'd1);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("b2b_second", 32'(data_out), 32'hA);
    check("b2b_second_v", 32'(data_valid), 32'h1);
    check("b2b_overrun", 32'(overrun), 32'h0);
    check("b2b_idle", 32'(busy), 32'h0);

    // same frames without ack: second word dropped
    do_reset();
    send_bits(4'h3);
    cyc(1'b1, 1'b0, 1'b0);
    send_bits(4'hA);
    check("ovr_before", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    check("ovr_data", 32'(data_out), 32'h3);
    check("ovr_valid", 32'(data_valid), 32'h1);
    check("ovr_flag", 32'(overrun), 32'h1);

    // asynchronous reset in mid-frame
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    check("mid_cnt3", 32'(counter), 32'd3);
    reset = 1'b1;
    #2;
    check("arst_data", 32'(data_out), 32'h0);
    check("arst_valid", 32'(data_valid), 32'h0);
    check("arst_cnt", 32'(counter), 32'h0);
    check("arst_busy", 32'(busy), 32'h0);
    check("arst_overrun", 32'(overrun), 32'h0);
    cyc(1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    // frame 4'hD with correct parity bit, then an aborted frame, then 4'h5
    send_bits(4'hD);
    cyc(1'b0, 1'b1, 1'b0);
    check("ab_pre_data", 32'(data_out), 32'hD);
    check("ab_pre_par", 32'(parity_err), 32'h0);
    cyc(1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b1, 1'b0);
    cyc(1'b0, 1'b0, 1'b0);
    check("ab_flag", 32'(abort_err), 32'h1);
    check("ab_cnt", 32'(counter), 32'h0);
    check("ab_idle", 32'(busy), 32'h0);
    check("ab_valid", 32'(data_valid), 32'h1);
    check("ab_data", 32'(data_out), 32'hD);
    send_bits(4'h5);
    cyc(1'b0, 1'b0, 1'b1);
    check("ab_next_data", 32'(data_out), 32'h5);
    check("ab_next_valid", 32'(data_valid), 32'h1);
    check("ab_next_ovr", 32'(overrun), 32'h0);
    check("ab_sticky", 32'(abort_err), 32'h1);

    // parity slot: 4'hD needs parity bit 1
    send_bits(4'hD);
    cyc(1'b0, 1'b0, 1'b1);
    check("par_bad_data", 32'(data_out), 32'hD);
`ifdef SERIAL_RX_PARITY_EN
    check("par_bad_flag", 32'(parity_err), 32'h1);
`else
    check("par_tied", 32'(parity_err), 32'h0);
`endif
    cyc(1'b0, 1'b0, 1'b1);
    check("ack_clr_valid", 32'(data_valid), 32'h0);
    check("ack_clr_par", 32'(parity_err), 32'h0);
    cyc(1'b0, 1'b0, 1'b1);
    check("ack_idle_ignored", 32'(data_valid), 32'h0);
    send_bits(4'hD);
    cyc(1'b0, 1'b1, 1'b0);
    check("par_good_flag", 32'(parity_err), 32'h0);
    check("par_good_valid", 32'(data_valid), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
